// File: rtl/uart_fifo.sv
// uart_fifo: MC6850-compatible UART with TX/RX FIFOs, 16-bit baud divisor and all 6850 word formats.
// Optional RTS/CTS hardware flow control is compiled in when UART_HWFLOW_EN is defined.
module uart_fifo #(
  parameter int unsigned FIFO_AW   = 4,
  parameter logic [15:0] RESET_DIV = 16'd26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  input  logic       cts_b,
  output logic       rts_b,
  input  logic       cs_b,
  input  logic       rnw,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq_b
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic               cs_q, acc, wr_ctrl, wr_data, wr_dlo, wr_dhi, rd_data, mr;
  logic [7:2]         ctrl;
  logic [15:0]        div, bcnt;
  logic               tick, bits7, par_en, par_odd, stop2, tx_brk, cts_ok, cts_bit, rts_next;
  logic [2:0]         last_bit;
  logic [7:0]         tx_mem [DEPTH];
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]      tx_cnt, rx_cnt;
  logic               tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]         tx_head, rx_last;
  state_t             tx_st, rx_st;
  logic [3:0]         tx_sub, rx_sub;
  logic [2:0]         tx_bit, rx_bit;
  logic [7:0]         tx_sh, rx_sh;
  logic               tx_par, tx_stop2nd, tx_go, rx_s1, rx_s2, rx_prev, rx_par, rx_done;
  logic               fe, pe, ovrn, irq_cond;

  assign acc     = cs_q & ~cs_b;
  assign wr_ctrl = acc & ~rnw & (addr == 2'd0);
  assign wr_data = acc & ~rnw & (addr == 2'd1);
  assign wr_dlo  = acc & ~rnw & (addr == 2'd2);
  assign wr_dhi  = acc & ~rnw & (addr == 2'd3);
  assign rd_data = acc &  rnw & (addr == 2'd1);
  assign mr      = wr_ctrl & (din[1:0] == 2'b11);

  // Word format: 0..7 = 7e2, 7o2, 7e1, 7o1, 8n2, 8n1, 8e1, 8o1
  assign bits7    = ~ctrl[4];
  assign par_en   = (ctrl[4:2] != 3'd4) && (ctrl[4:2] != 3'd5);
  assign par_odd  = ctrl[2];
  assign stop2    = (ctrl[4:2] == 3'd0) || (ctrl[4:2] == 3'd1) || (ctrl[4:2] == 3'd4);
  assign last_bit = bits7 ? 3'd6 : 3'd7;
  assign tx_brk   = (ctrl[6:5] == 2'b11);

`ifdef UART_HWFLOW_EN
  assign cts_ok   = ~cts_b;
  assign cts_bit  = cts_b;
  assign rts_next = (rx_cnt >= CW'(DEPTH - 2));
`else
  logic unused_cts;
  assign unused_cts = cts_b;
  assign cts_ok     = 1'b1;
  assign cts_bit    = 1'b0;
  assign rts_next   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q <= 1'b1;
      ctrl <= 6'b000101;
      div  <= RESET_DIV;
    end else begin
      cs_q <= cs_b;
      if (wr_ctrl) ctrl <= din[7:2];
      if (wr_dlo)  div[7:0]  <= din;
      if (wr_dhi)  div[15:8] <= din;
    end
  end

  // Oversample tick: counts DIV down to zero, ticks and reloads
  assign tick = (bcnt == 16'd0);
  always_ff @(posedge clk) begin
    if (reset)     bcnt <= RESET_DIV;
    else if (tick) bcnt <= div;
    else           bcnt <= bcnt - 16'd1;
  end

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign tx_head  = tx_mem[tx_rp];
  assign tx_push  = wr_data & ~tx_full;
  assign rx_pop   = rd_data & ~rx_empty;
  assign rx_done  = (rx_st == S_STOP) && tick && (rx_sub == 4'd15);
  assign rx_push  = rx_done & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= din;
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge clk) begin
    if (reset || mr) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + FIFO_AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + FIFO_AW'(1);
      if (rx_push) rx_wp <= rx_wp + FIFO_AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + FIFO_AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Holds the last popped byte so a read of an empty FIFO repeats it
  always_ff @(posedge clk) begin
    if (reset)       rx_last <= 8'h00;
    else if (rx_pop) rx_last <= rx_mem[rx_rp];
  end

  // A new character starts from IDLE, or straight out of the final stop bit
  assign tx_go  = ~tx_empty & ~tx_brk & cts_ok;
  assign tx_pop = tick & tx_go &
                  ((tx_st == S_IDLE) ||
                   ((tx_st == S_STOP) && (tx_sub == 4'd15) && !(stop2 && !tx_stop2nd)));

  always_ff @(posedge clk) begin
    if (reset || mr) begin
      tx_st <= S_IDLE; txd <= 1'b1; tx_sub <= '0; tx_bit <= '0;
      tx_sh <= '0; tx_par <= 1'b0; tx_stop2nd <= 1'b0;
    end else if (tx_pop) begin
      tx_st <= S_START; txd <= 1'b0; tx_sub <= '0; tx_stop2nd <= 1'b0;
      tx_sh <= tx_head;
      tx_par <= par_odd ^ (^(tx_head & {~bits7, 7'h7f}));
    end else begin
      case (tx_st)
        S_IDLE: txd <= ~tx_brk;
        S_START: if (tick) begin
          tx_sub <= tx_sub + 4'd1;
          if (tx_sub == 4'd15) begin tx_st <= S_DATA; txd <= tx_sh[0]; tx_bit <= '0; end
        end
        S_DATA: if (tick) begin
          tx_sub <= tx_sub + 4'd1;
          if (tx_sub == 4'd15) begin
            if (tx_bit != last_bit) begin
              tx_bit <= tx_bit + 3'd1; tx_sh <= tx_sh >> 1; txd <= tx_sh[1];
            end else if (par_en) begin
              tx_st <= S_PARITY; txd <= tx_par;
            end else begin
              tx_st <= S_STOP; txd <= 1'b1;
            end
          end
        end
        S_PARITY: if (tick) begin
          tx_sub <= tx_sub + 4'd1;
          if (tx_sub == 4'd15) begin tx_st <= S_STOP; txd <= 1'b1; end
        end
        S_STOP: if (tick) begin
          tx_sub <= tx_sub + 4'd1;
          if (tx_sub == 4'd15) begin
            if (stop2 && !tx_stop2nd) tx_stop2nd <= 1'b1;
            else begin tx_st <= S_IDLE; txd <= ~tx_brk; end
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // Receiver: edge-armed, so a held-low break re-arms only after rxd returns high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
    end else begin
      rx_s1 <= rxd; rx_s2 <= rx_s1; rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || mr) begin
      rx_st <= S_IDLE; rx_sub <= '0; rx_bit <= '0; rx_sh <= '0; rx_par <= 1'b0;
    end else begin
      case (rx_st)
        S_IDLE: if (rx_prev && !rx_s2) begin
          rx_st <= S_START; rx_sub <= '0; rx_bit <= '0; rx_sh <= '0;
        end
        S_START: if (tick) begin
          rx_sub <= rx_sub + 4'd1;
          if (rx_sub == 4'd7) begin
            if (rx_s2) rx_st <= S_IDLE;
            else begin rx_st <= S_DATA; rx_sub <= '0; end
          end
        end
        S_DATA: if (tick) begin
          rx_sub <= rx_sub + 4'd1;
          if (rx_sub == 4'd15) begin
            rx_sh[rx_bit] <= rx_s2;
            if (rx_bit != last_bit) rx_bit <= rx_bit + 3'd1;
            else rx_st <= par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: if (tick) begin
          rx_sub <= rx_sub + 4'd1;
          if (rx_sub == 4'd15) begin rx_par <= rx_s2; rx_st <= S_STOP; end
        end
        S_STOP: if (tick) begin
          rx_sub <= rx_sub + 4'd1;
          if (rx_sub == 4'd15) rx_st <= S_IDLE;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a data-read clear wins
  always_ff @(posedge clk) begin
    if (reset || mr) begin
      fe <= 1'b0; pe <= 1'b0; ovrn <= 1'b0;
    end else begin
      fe   <= (rx_done & ~rx_s2) | (fe & ~rd_data);
      pe   <= (rx_done & par_en & (rx_par != (par_odd ^ (^rx_sh)))) | (pe & ~rd_data);
      ovrn <= (rx_done & rx_full & ~rx_pop) | (ovrn & ~rd_data);
    end
  end

  assign irq_cond = ((ctrl[6:5] == 2'b01) && tx_empty) || (ctrl[7] && (!rx_empty || ovrn));

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_b <= 1'b1; rts_b <= 1'b0;
    end else begin
      irq_b <= ~irq_cond; rts_b <= rts_next;
    end
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      2'd0: dout = {~irq_b, pe, ovrn, fe, cts_bit, 1'b0, ~tx_full, ~rx_empty};
      2'd1: dout = rx_empty ? rx_last : rx_mem[rx_rp];
      2'd2: dout = div[7:0];
      default: dout = div[15:8];
    endcase
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: register vector table plus serial/loopback sequences.
module tb_uart_fifo;
  logic       clk = 1'b0;
  logic       reset, rxd, txd, cts_b, rts_b, cs_b, rnw, irq_b;
  logic [1:0] addr;
  logic [7:0] din, dout;
  logic       loopback, rx_drv;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;
  assign rxd = loopback ? txd : rx_drv;

  uart_fifo dut (
    .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .cts_b(cts_b), .rts_b(rts_b),
    .cs_b(cs_b), .rnw(rnw), .addr(addr), .din(din), .dout(dout), .irq_b(irq_b)
  );

  typedef struct {
    bit         wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    logic       exp_irq_b;
  } vec_t;

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); cs_b = 1'b0; rnw = 1'b0; addr = a; din = d;
    @(negedge clk); cs_b = 1'b1; rnw = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk); cs_b = 1'b0; rnw = 1'b1; addr = a;
    #1 d = dout;
    @(negedge clk); cs_b = 1'b1;
  endtask

  task automatic read_check(input string nm, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] got;
    bus_read(a, got);
    check8(nm, got, exp);
  endtask

  task automatic wait_txd_low(output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin ok = 1'b1; n = i; break; end
    end
  endtask

  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic count_txd_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[16];
    logic [7:0] a5 = 8'hA5;
    logic [11:0] fr;
    bit         ok;
    int         n, lows;

    vt[0]  = '{1'b0, 2'd2, 8'h00, 8'h1A, 1'b1};
    vt[1]  = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b1};
    vt[2]  = '{1'b0, 2'd0, 8'h00, 8'h02, 1'b1};
    vt[3]  = '{1'b1, 2'd3, 8'h12, 8'h00, 1'b1};
    vt[4]  = '{1'b0, 2'd3, 8'h00, 8'h12, 1'b1};
    vt[5]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b1};
    vt[6]  = '{1'b1, 2'd2, 8'h00, 8'h00, 1'b1};
    vt[7]  = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b1};
    vt[8]  = '{1'b0, 2'd1, 8'h00, 8'h00, 1'b1};
    vt[9]  = '{1'b1, 2'd0, 8'hA0, 8'h00, 1'b1};
    vt[10] = '{1'b0, 2'd0, 8'h00, 8'h82, 1'b0};
    vt[11] = '{1'b1, 2'd0, 8'h14, 8'h00, 1'b1};
    vt[12] = '{1'b0, 2'd0, 8'h00, 8'h02, 1'b1};
    vt[13] = '{1'b1, 2'd0, 8'h94, 8'h00, 1'b1};
    vt[14] = '{1'b0, 2'd0, 8'h00, 8'h02, 1'b1};
    vt[15] = '{1'b1, 2'd0, 8'h14, 8'h00, 1'b1};

    reset = 1'b1; cs_b = 1'b1; rnw = 1'b1; addr = 2'd0; din = 8'h00;
    cts_b = 1'b0; loopback = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check1("reset_txd", txd, 1'b1);
    check1("reset_rts_b", rts_b, 1'b0);
    check1("reset_irq_b", irq_b, 1'b1);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) bus_write(vt[i].a, vt[i].d);
      else begin
        logic [7:0] got;
        bus_read(vt[i].a, got);
        check8($sformatf("vec%0d_dout", i), got, vt[i].exp);
        check1($sformatf("vec%0d_irq_b", i), irq_b, vt[i].exp_irq_b);
      end
    end

    // 8n1 transmit of 0xA5 at DIV=0
    repeat (40) @(negedge clk);
    bus_write(2'd1, 8'hA5);
    wait_txd_low(ok, n);
    check1("a5_start_seen", ok, 1'b1);
    check1("a5_start_within_tick", (n <= 1), 1'b1);
    repeat (8) @(negedge clk);
    check1("a5_start_bit", txd, 1'b0);
    for (int b = 0; b < 8; b++) begin
      repeat (16) @(negedge clk);
      check1($sformatf("a5_bit%0d", b), txd, a5[b]);
      check1($sformatf("a5_irq_b%0d", b), irq_b, 1'b1);
    end
    repeat (16) @(negedge clk);
    check1("a5_stop_bit", txd, 1'b1);
    read_check("a5_status_after", 2'd0, 8'h02);

    // 7e1 loopback, then a frame with a wrong parity bit
    bus_write(2'd0, 8'h08);
    loopback = 1'b1;
    bus_write(2'd1, 8'h41);
    repeat (300) @(negedge clk);
    read_check("7e1_status", 2'd0, 8'h03);
    read_check("7e1_data", 2'd1, 8'h41);
    read_check("7e1_status_empty", 2'd0, 8'h02);
    loopback = 1'b0;
    fr = {2'b11, 1'b1, 1'b1, 7'h41, 1'b0};
    send_bits(fr, 10);
    repeat (20) @(negedge clk);
    read_check("pe_status", 2'd0, 8'h43);
    read_check("pe_data", 2'd1, 8'h41);
    read_check("pe_cleared", 2'd0, 8'h02);

    // Overrun: 17 characters into a 16-deep RX FIFO
    bus_write(2'd0, 8'h14);
    loopback = 1'b1;
    for (int i = 1; i <= 17; i++) bus_write(2'd1, 8'(i));
    repeat (3200) @(negedge clk);
    read_check("ovrn_status", 2'd0, 8'h23);
    for (int i = 1; i <= 16; i++) read_check($sformatf("ovrn_data%0d", i), 2'd1, 8'(i));
    read_check("ovrn_status_empty", 2'd0, 8'h02);
    read_check("empty_read_last_head", 2'd1, 8'd16);
    read_check("empty_read_no_pop", 2'd0, 8'h02);
    loopback = 1'b0;

    // TX FIFO overflow held in break, then drained with TX interrupt enabled
    bus_write(2'd0, 8'h74);
    for (int i = 1; i <= 20; i++) bus_write(2'd1, 8'(i));
    read_check("txfull_status", 2'd0, 8'h00);
    check1("break_txd", txd, 1'b0);
    bus_write(2'd2, 8'd100);
    bus_write(2'd0, 8'h34);
    repeat (3) @(negedge clk);
    check1("break_released_txd", txd, 1'b1);
    check1("txie_full_irq_b", irq_b, 1'b1);
    loopback = 1'b1;
    bus_write(2'd2, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (irq_b === 1'b0) begin ok = 1'b1; break; end
    end
    check1("txie_irq_on_empty", ok, 1'b1);
    repeat (400) @(negedge clk);
    read_check("drain_status", 2'd0, 8'h83);
    for (int i = 1; i <= 16; i++) read_check($sformatf("drain_data%0d", i), 2'd1, 8'(i));
    read_check("drain_status_empty", 2'd0, 8'h82);
    bus_write(2'd0, 8'h14);
    loopback = 1'b0;
    repeat (2) @(negedge clk);
    check1("txie_off_irq_b", irq_b, 1'b1);

    // Received break and a short glitch
    rx_drv = 1'b0;
    repeat (320) @(negedge clk);
    rx_drv = 1'b1;
    repeat (50) @(negedge clk);
    read_check("rxbreak_status", 2'd0, 8'h13);
    read_check("rxbreak_data", 2'd1, 8'h00);
    read_check("rxbreak_one_push", 2'd0, 8'h02);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    read_check("glitch_no_push", 2'd0, 8'h02);

    // Master reset mid-character with a pending FE and RX byte
    rx_drv = 1'b0;
    repeat (320) @(negedge clk);
    rx_drv = 1'b1;
    repeat (50) @(negedge clk);
    read_check("mr_pre_status", 2'd0, 8'h13);
    bus_write(2'd1, 8'h55);
    bus_write(2'd1, 8'hAA);
    wait_txd_low(ok, n);
    check1("mr_tx_started", ok, 1'b1);
    repeat (40) @(negedge clk);
    bus_write(2'd0, 8'h17);
    check1("mr_txd_high", txd, 1'b1);
    count_txd_low(300, lows);
    check1("mr_tx_flushed", (lows == 0), 1'b1);
    read_check("mr_status", 2'd0, 8'h02);
    read_check("mr_div_kept", 2'd2, 8'h00);

`ifdef UART_HWFLOW_EN
    loopback = 1'b1;
    for (int i = 0; i < 14; i++) bus_write(2'd1, 8'(8'h30 + i));
    repeat (2600) @(negedge clk);
    check1("rts_at_14", rts_b, 1'b1);
    read_check("rts_status", 2'd0, 8'h03);
    read_check("rts_first_data", 2'd1, 8'h30);
    repeat (3) @(negedge clk);
    check1("rts_at_13", rts_b, 1'b0);
    cts_b = 1'b1;
    read_check("cts_status_bit", 2'd0, 8'h0B);
    bus_write(2'd1, 8'h77);
    count_txd_low(200, lows);
    check1("cts_holds_tx", (lows == 0), 1'b1);
    cts_b = 1'b0;
    wait_txd_low(ok, n);
    check1("cts_release_tx", ok, 1'b1);
    loopback = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
